result_buffer: RTL and testbench
================================

RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the width of each result word.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 6, which sets storage depth to 2^DEPTH_LOG2 words.
REQ-003 The block SHALL have port clock, input, 1 bit: the system clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port wr_data, input, DATA_WIDTH bits: result word from the pulse sequencer's result port.
REQ-006 The block SHALL have port wr_req, input, 1 bit: write request; a word is written on each rising edge.
REQ-007 The block SHALL have port rd_data, output, DATA_WIDTH bits: head word.
REQ-008 The block SHALL have port rd_valid, output, 1 bit: rd_data holds a valid word.
REQ-009 The block SHALL have port rd_ready, input, 1 bit: the consumer accepts the head word.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all stored words.
REQ-011 The block SHALL have port clear_overflow, input, 1 bit: clear the sticky overflow flag.
REQ-012 The block SHALL have port count, output, DEPTH_LOG2+1 bits: number of stored words.
REQ-013 The block SHALL have port full, output, 1 bit: count equals 2^DEPTH_LOG2.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag set when a word is dropped.
REQ-015 The block SHALL have port drop_count, output, 16 bits: number of dropped words (see Configuration).

Function
REQ-016 The block SHALL register wr_req every cycle and detect a push when wr_req=1 and the registered value=0; wr_data is sampled in that same cycle.
REQ-017 The block SHALL treat wr_req held high for N cycles as exactly one push.
REQ-018 The block SHALL implement a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap from 2^DEPTH_LOG2-1 to 0.
REQ-019 The block SHALL present the head word first-word-fall-through: a push into an empty buffer gives rd_valid=1 and rd_data=word on the following cycle.
REQ-020 The block SHALL pop the head word in a cycle where rd_valid=1 and rd_ready=1; the next word, if any, SHALL be on rd_data the following cycle with no bubble.
REQ-021 The block SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-022 With a push and a pop in the same cycle, the block SHALL accept both and leave count unchanged, including when full.
REQ-023 With a push while full and no pop, the block SHALL drop the word, leave storage unchanged, and set overflow=1 on the next cycle.
REQ-024 overflow SHALL remain set until clear_overflow=1 or reset; if clear_overflow and a drop coincide, overflow SHALL end at 1.
REQ-025 flush SHALL, on the next cycle, zero count and both pointers and deassert rd_valid.
REQ-026 A push coincident with flush SHALL be discarded without setting overflow; a pop coincident with flush SHALL have no further effect.
REQ-027 count, full and rd_valid SHALL be registered outputs consistent with one another every cycle.

Reset
REQ-028 Reset SHALL asynchronously clear pointers, count, rd_valid, full, overflow, drop_count, rd_data and the registered wr_req to 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored words.
REQ-030 After reset deasserts with wr_req already high, the block SHALL NOT record a push until wr_req falls and rises again.

Configuration
REQ-031 With macro RESULT_BUFFER_DROP_CNT_EN defined, drop_count SHALL increment on each dropped word, saturate at 65535, and clear on clear_overflow, flush or reset.
REQ-032 Without RESULT_BUFFER_DROP_CNT_EN, drop_count SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification
REQ-033 Reset, then pulse wr_req for 1 cycle with wr_data=0xDEADBEEF -> next cycle rd_valid=1, rd_data=0xDEADBEEF, count=1.
REQ-034 Hold wr_req high 5 cycles with changing wr_data -> exactly one word stored, equal to the value present on the rising-edge cycle.
REQ-035 Push 64 words 0..63 with rd_ready=0, then push 0xAA -> full=1, overflow=1, drop_count=1 (if enabled); drain -> reads 0..63 in order, no 0xAA.
REQ-036 With the buffer full, push and pop in the same cycle -> count stays 64, overflow stays 0, the new word is read out last.
REQ-037 Store 10 words, then assert flush in the same cycle as a push -> count=0 and rd_valid=0 next cycle, overflow=0.
REQ-038 Cycle wr_pointer through 3 full wraps with rd_ready=1 and random gaps -> output order matches input order and count never exceeds 64.

Source files
------------

// File: rtl/result_buffer.sv
// result_buffer
//   Circular FIFO that collects result words from the pulse sequencer and
//   presents them first-word-fall-through to a ready/valid consumer.
//   A write is recorded on each rising edge of wr_req. Words arriving while
//   the buffer is full are dropped, and a sticky overflow flag records this.
//
// Parameters
//   DATA_WIDTH  width of each result word
//   DEPTH_LOG2  storage depth is 2**DEPTH_LOG2 words
//
// Ports
//   clock, reset      system clock; asynchronous active-high reset
//   wr_data, wr_req   result word and write request (edge-detected)
//   rd_data, rd_valid head word and its valid flag
//   rd_ready          consumer accepts the head word
//   flush             discard all stored words
//   clear_overflow    clear the sticky overflow flag (and drop_count)
//   count, full       number of stored words; buffer-full flag
//   overflow          sticky flag, set when a word is dropped
//   drop_count        number of dropped words (saturating)
//
// Configuration macro
//   RESULT_BUFFER_DROP_CNT_EN  builds the drop counter; when undefined
//                              drop_count is tied to 0.

module result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    input  logic                  flush,
    input  logic                  clear_overflow,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_rd_valid;
    logic                  r_full;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_wr_req_d;
    logic                  r_armed;

    logic                  w_push_edge;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic [DATA_WIDTH-1:0] w_head_nxt;

    // r_armed stays low after reset until wr_req has been seen low, so a
    // request already high when reset releases is not taken as a new edge.
    assign w_push_edge = wr_req & ~r_wr_req_d & r_armed;
    assign w_pop       = r_rd_valid & rd_ready & ~flush;
    assign w_push      = w_push_edge & ~flush & (~r_full | w_pop);
    assign w_drop      = w_push_edge & ~flush & r_full & ~w_pop;

    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        if (flush) begin
            w_rd_ptr_nxt = '0;
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr + DEPTH_LOG2'(w_pop);
            w_wr_ptr_nxt = r_wr_ptr + DEPTH_LOG2'(w_push);
            w_count_nxt  = r_count + (DEPTH_LOG2 + 1)'(w_push)
                                   - (DEPTH_LOG2 + 1)'(w_pop);
        end
    end

    // Next head word: bypass the incoming word when it lands on the slot
    // that becomes the head (push into an empty buffer), else read storage.
    always_comb begin
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt))
            w_head_nxt = wr_data;
        else
            w_head_nxt = r_mem[w_rd_ptr_nxt];
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_rd_data  <= '0;
            r_wr_req_d <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_wr_req_d <= wr_req;
            if (!wr_req)
                r_armed <= 1'b1;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != '0);
            r_full     <= (w_count_nxt == DEPTH_CNT);
            if (w_count_nxt != '0)
                r_rd_data <= w_head_nxt;
            // A drop wins over a coincident clear.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clear_overflow)
                r_overflow <= 1'b0;
        end
    end

`ifdef RESULT_BUFFER_DROP_CNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (clear_overflow || flush) begin
            r_drop_count <= w_drop ? 16'd1 : '0;
        end else if (w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = r_full;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_result_buffer.sv
// Testbench for result_buffer: stimulus drives inputs and steps a queue-based
// reference model at each clock edge; expected words are pushed to a
// scoreboard queue which a negedge monitor compares against the DUT.
module tb_result_buffer;

    localparam int DW    = 32;
    localparam int DL2   = 6;
    localparam int DEPTH = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_req = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          flush = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [DL2:0]  count;
    logic          full;
    logic          overflow;
    logic [15:0]   drop_count;

    always #5 clock = ~clock;

    result_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
        .clock          (clock),
        .reset          (reset),
        .wr_data        (wr_data),
        .wr_req         (wr_req),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: buffer contents, edge detector, sticky flags.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    bit            m_prev  = 1'b0;
    bit            m_armed = 1'b0;
    bit            m_ovf   = 1'b0;
    int            m_drops = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_drops();
`ifdef RESULT_BUFFER_DROP_CNT_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    // Apply the rules for one clock edge using the inputs sampled at it.
    function automatic void model_edge();
        bit push, pop, drop;
        if (reset) begin
            mq.delete();
            sb.delete();
            m_prev  = 1'b0;
            m_armed = 1'b0;
            m_ovf   = 1'b0;
            m_drops = 0;
            return;
        end
        push = wr_req && !m_prev && m_armed;
        drop = 1'b0;
        if (flush) begin
            mq.delete();
            sb.delete();
        end else begin
            pop = (mq.size() > 0) && rd_ready;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() == DEPTH) drop = 1'b1;
                else begin
                    mq.push_back(wr_data);
                    sb.push_back(wr_data);
                end
            end
        end
        if (clear_overflow) m_ovf = 1'b0;
        if (clear_overflow || flush) m_drops = 0;
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
        m_prev = wr_req;
        if (!wr_req) m_armed = 1'b1;
    endfunction

    task automatic step(input bit req, input logic [DW-1:0] d, input bit rdy,
                        input bit fl, input bit clr);
        wr_req = req;
        wr_data = d;
        rd_ready = rdy;
        flush = fl;
        clear_overflow = clr;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input bit rdy);
        step(1'b1, d, rdy, 1'b0, 1'b0);
        step(1'b0, $urandom, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: compare status against the model and the head word against
    // the scoreboard; retire scoreboard entries on accepted pops.
    always @(negedge clock) begin
        if (reset) begin
            chk("reset_count", count, 0);
            chk("reset_rd_valid", rd_valid, 0);
            chk("reset_full", full, 0);
            chk("reset_overflow", overflow, 0);
            chk("reset_drop_count", drop_count, 0);
            chk("reset_rd_data", rd_data, 0);
        end else begin
            chk("count", count, mq.size());
            chk("count_le_depth", count <= DEPTH, 1);
            chk("rd_valid", rd_valid, mq.size() != 0);
            chk("full", full, mq.size() == DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("drop_count", drop_count, exp_drops());
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_data_unexpected actual=%0h expected=none", rd_data);
                end else begin
                    chk("rd_data", rd_data, sb[0]);
                    if (rd_ready && !flush) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        idle(3, 1'b0);
        reset = 1'b0;
        idle(2, 1'b0);

        // Single pulse, FWFT after one cycle
        push_word(32'hDEADBEEF, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // wr_req held high for 5 cycles with changing data: one word only
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Fill to full, drop 0xAA, drop with coincident clear, drain
        for (int i = 0; i < DEPTH; i++) push_word(i, 1'b0);
        push_word(32'hAA, 1'b0);
        step(1'b1, 32'hBB, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        idle(DEPTH + 2, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push_word(32'h1000 + i, 1'b0);
        step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(DEPTH + 2, 1'b1);

        // Flush coincident with a push
        for (int i = 0; i < 10; i++) push_word(32'h2000 + i, 1'b0);
        step(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Reset mid-operation with wr_req held high through release
        for (int i = 0; i < 5; i++) push_word(32'h3000 + i, 1'b0);
        step(1'b1, 32'h3100, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 32'h3101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h3102, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h3200 + i, 1'b0, 1'b0, 1'b0);
        push_word(32'h99, 1'b0);
        idle(3, 1'b1);

        // Random traffic, consumer mostly ready: several pointer wraps
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 7) != 0, 1'b0, 1'b0);
        idle(DEPTH + 2, 1'b1);

        // Random traffic with a slow consumer, flushes and clears
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0);
        idle(DEPTH + 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
